// File: rtl/blink_pkg.sv
// Shared constants for the LED blink sequencer: state encoding, default sizing
// and the configuration values loaded at reset.
package blink_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } state_e;

  localparam int DEF_TICK_DIV = 50000000;
  localparam int DEF_CNT_W    = 8;
  localparam int DEF_REP_W    = 4;

  localparam int CFG_ON_RST   = 1;
  localparam int CFG_OFF_RST  = 1;
  localparam int CFG_REPS_RST = 0;
endpackage

// File: rtl/blink_sequencer_if.sv
// Configuration handshake, run control and status of the blink sequencer.
interface blink_sequencer_if import blink_pkg::*; #(
  parameter int CNT_W = DEF_CNT_W,
  parameter int REP_W = DEF_REP_W
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CNT_W-1:0] cfg_on;
  logic [CNT_W-1:0] cfg_off;
  logic [REP_W-1:0] cfg_reps;
  logic             start;
  logic             stop;
  logic             led;
  logic             busy;
  logic             done;
  logic             tick;

  modport master (
    output cfg_valid, cfg_on, cfg_off, cfg_reps, start, stop,
    input  cfg_ready, led, busy, done, tick
  );

  modport slave (
    input  cfg_valid, cfg_on, cfg_off, cfg_reps, start, stop,
    output cfg_ready, led, busy, done, tick
  );
endinterface

// File: rtl/blink_sequencer_tick_prescaler.sv
// Free-running clock divider that emits a one-cycle tick every TICK_DIV enabled
// cycles; clr restarts the count so a new sequence gets full-length phases.
module tick_prescaler import blink_pkg::*; #(
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int TICK_W = $clog2(TICK_DIV);

  logic [TICK_W-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = en && (cnt_q == TICK_W'(TICK_DIV - 1));
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end
endmodule

// File: rtl/blink_sequencer.sv
// LED blink sequencer: runs a programmable on/off pattern, bounded or endless,
// paced by the tick prescaler; config loads through a valid/ready handshake.
module blink_sequencer import blink_pkg::*; #(
  parameter int TICK_DIV = DEF_TICK_DIV,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int REP_W    = DEF_REP_W
) (
  input  logic               clk,
  input  logic               rst,
  blink_sequencer_if.slave   bus
);
  state_e           state_q, state_d;
  logic [CNT_W-1:0] on_q, on_d, off_q, off_d, phase_q, phase_d;
  logic [REP_W-1:0] reps_q, reps_d, rep_q, rep_d;
  logic             led_q, led_d, done_q, done_d;
  logic [REP_W:0]   rep_inc;
  logic             end_cycle;
  logic             tick, busy, pre_clr;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_pre (
    .clk  (clk),
    .rst  (rst),
    .en   (busy),
    .clr  (pre_clr),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      on_q    <= CNT_W'(CFG_ON_RST);
      off_q   <= CNT_W'(CFG_OFF_RST);
      reps_q  <= REP_W'(CFG_REPS_RST);
      phase_q <= '0;
      rep_q   <= '0;
      led_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      on_q    <= on_d;
      off_q   <= off_d;
      reps_q  <= reps_d;
      phase_q <= phase_d;
      rep_q   <= rep_d;
      led_q   <= led_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    on_d      = on_q;
    off_d     = off_q;
    reps_d    = reps_q;
    phase_d   = phase_q;
    rep_d     = rep_q;
    led_d     = led_q;
    done_d    = 1'b0;
    end_cycle = 1'b0;
    rep_inc   = {1'b0, rep_q} + 1'b1;

    if (bus.cfg_valid && state_q == IDLE) begin
      on_d   = bus.cfg_on;
      off_d  = bus.cfg_off;
      reps_d = bus.cfg_reps;
    end

    case (state_q)
      IDLE: if (bus.start && !bus.stop) begin
        if (on_q != '0) begin
          state_d = ON;
          led_d   = 1'b1;
          phase_d = on_q;
          rep_d   = '0;
        end else begin
          done_d  = 1'b1;
        end
      end
      ON: if (tick) begin
        if (phase_q == CNT_W'(1)) begin
          if (off_q != '0) begin
            state_d = OFF;
            led_d   = 1'b0;
            phase_d = off_q;
          end else begin
            end_cycle = 1'b1;
          end
        end else begin
          phase_d = phase_q - 1'b1;
        end
      end
      OFF: if (tick) begin
        if (phase_q == CNT_W'(1)) end_cycle = 1'b1;
        else                      phase_d   = phase_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (end_cycle) begin
      if (reps_q != '0 && rep_inc == {1'b0, reps_q}) begin
        state_d = IDLE;
        led_d   = 1'b0;
        done_d  = 1'b1;
      end else begin
        state_d = ON;
        led_d   = 1'b1;
        phase_d = on_q;
        // endless runs park the counter at all-ones instead of wrapping
        rep_d   = (&rep_q) ? rep_q : rep_inc[REP_W-1:0];
      end
    end

    if (bus.stop && state_q != IDLE) begin
      state_d = IDLE;
      led_d   = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_comb begin
    busy          = (state_q != IDLE);
    // restart the prescaler on every launch and on abort
    pre_clr       = (state_q == IDLE) ? (bus.start && !bus.stop) : bus.stop;
    bus.cfg_ready = (state_q == IDLE);
    bus.busy      = busy;
    bus.led       = led_q;
    bus.done      = done_q;
    bus.tick      = tick;
  end
endmodule

// File: tb/tb_blink_sequencer.sv
// Scoreboard bench for blink_sequencer with TICK_DIV=4: per-cycle expected
// {cfg_ready, led, busy, done, tick} tuples are queued and compared on negedges.
module tb_blink_sequencer;
  typedef struct packed {
    logic rdy;
    logic led;
    logic busy;
    logic done;
    logic tick;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  obs_t sb[$];
  obs_t exp_o, got;

  always #5 clk = ~clk;

  blink_sequencer_if #(.CNT_W(8), .REP_W(4)) bif ();

  blink_sequencer #(.TICK_DIV(4), .CNT_W(8), .REP_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  function automatic obs_t sample();
    return {bif.cfg_ready, bif.led, bif.busy, bif.done, bif.tick};
  endfunction

  // n running cycles at a given LED level; tick lands on every 4th cycle
  task automatic push_pat(input int n, input logic led);
    for (int i = 0; i < n; i++)
      sb.push_back({1'b0, led, 1'b1, 1'b0, logic'(i % 4 == 3)});
  endtask

  task automatic push_idle(input int n, input logic done_first);
    for (int i = 0; i < n; i++)
      sb.push_back({1'b1, 1'b0, 1'b0, logic'(done_first && i == 0), 1'b0});
  endtask

  task automatic load_cfg(input logic [7:0] on, input logic [7:0] off, input logic [3:0] reps);
    bif.cfg_valid = 1'b1;
    bif.cfg_on    = on;
    bif.cfg_off   = off;
    bif.cfg_reps  = reps;
    @(negedge clk);
    bif.cfg_valid = 1'b0;
  endtask

  task automatic pulse_start();
    bif.start = 1'b1;
    @(negedge clk);
    bif.start = 1'b0;
  endtask

  task automatic test_reset();
    bif.cfg_valid = 1'b0; bif.cfg_on = '0; bif.cfg_off = '0; bif.cfg_reps = '0;
    bif.start = 1'b0; bif.stop = 1'b0;
    #3;
    got = sample(); n_chk++;
    if (got !== 5'b10000) begin n_fail++; $display("FAIL reset_state: got %b want 10000", got); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    pulse_start();
    push_pat(4, 1'b1); push_pat(4, 1'b0); push_pat(4, 1'b1); push_pat(4, 1'b0);
    for (int k = 0; sb.size() > 0; k++) begin
      exp_o = sb.pop_front(); got = sample(); n_chk++;
      if (got !== exp_o) begin n_fail++; $display("FAIL default_pattern cyc %0d: got %b want %b", k, got, exp_o); end
      @(negedge clk);
    end
    n_chk++;
    if (bif.led !== 1'b1) begin n_fail++; $display("FAIL pre_reset_led: got %b want 1", bif.led); end
    #2 rst = 1'b0;
    #1;
    got = sample(); n_chk++;
    if (got !== 5'b10000) begin n_fail++; $display("FAIL async_reset: got %b want 10000", got); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    got = sample(); n_chk++;
    if (got !== 5'b10000) begin n_fail++; $display("FAIL post_reset_idle: got %b want 10000", got); end
  endtask

  task automatic test_bounded();
    load_cfg(8'd2, 8'd1, 4'd2);
    pulse_start();
    push_pat(8, 1'b1); push_pat(4, 1'b0); push_pat(8, 1'b1); push_pat(4, 1'b0);
    push_idle(2, 1'b1);
    for (int k = 0; sb.size() > 0; k++) begin
      exp_o = sb.pop_front(); got = sample(); n_chk++;
      if (got !== exp_o) begin n_fail++; $display("FAIL bounded cyc %0d: got %b want %b", k, got, exp_o); end
      @(negedge clk);
    end
  endtask

  task automatic test_endless_solid();
    load_cfg(8'd3, 8'd0, 4'd0);
    pulse_start();
    push_pat(120, 1'b1);
    for (int k = 0; sb.size() > 0; k++) begin
      exp_o = sb.pop_front(); got = sample(); n_chk++;
      if (got !== exp_o) begin n_fail++; $display("FAIL endless cyc %0d: got %b want %b", k, got, exp_o); end
      @(negedge clk);
    end
    bif.stop = 1'b1;
    @(negedge clk);
    bif.stop = 1'b0;
    push_idle(5, 1'b0);
    for (int k = 0; sb.size() > 0; k++) begin
      exp_o = sb.pop_front(); got = sample(); n_chk++;
      if (got !== exp_o) begin n_fail++; $display("FAIL stop cyc %0d: got %b want %b", k, got, exp_o); end
      @(negedge clk);
    end
  endtask

  task automatic test_zero_on();
    load_cfg(8'd0, 8'd1, 4'd1);
    pulse_start();
    push_idle(4, 1'b1);
    for (int k = 0; sb.size() > 0; k++) begin
      exp_o = sb.pop_front(); got = sample(); n_chk++;
      if (got !== exp_o) begin n_fail++; $display("FAIL zero_on cyc %0d: got %b want %b", k, got, exp_o); end
      @(negedge clk);
    end
  endtask

  task automatic test_handshake();
    load_cfg(8'd1, 8'd1, 4'd1);
    bif.start = 1'b1;
    @(negedge clk);
    bif.start = 1'b0;
    bif.cfg_valid = 1'b1; bif.cfg_on = 8'd2; bif.cfg_off = 8'd2; bif.cfg_reps = 4'd1;
    push_pat(4, 1'b1); push_pat(4, 1'b0);
    for (int k = 0; sb.size() > 0; k++) begin
      exp_o = sb.pop_front(); got = sample(); n_chk++;
      if (got !== exp_o) begin n_fail++; $display("FAIL hs_hold cyc %0d: got %b want %b", k, got, exp_o); end
      @(negedge clk);
    end
    got = sample(); n_chk++;
    if (got !== 5'b10010) begin n_fail++; $display("FAIL hs_done: got %b want 10010", got); end
    @(negedge clk);
    bif.cfg_valid = 1'b0;
    pulse_start();
    push_pat(8, 1'b1); push_pat(8, 1'b0); push_idle(2, 1'b1);
    for (int k = 0; sb.size() > 0; k++) begin
      exp_o = sb.pop_front(); got = sample(); n_chk++;
      if (got !== exp_o) begin n_fail++; $display("FAIL hs_new_cfg cyc %0d: got %b want %b", k, got, exp_o); end
      @(negedge clk);
    end
  endtask

  task automatic test_simultaneous();
    bif.start = 1'b1; bif.stop = 1'b1;
    @(negedge clk);
    bif.start = 1'b0; bif.stop = 1'b0;
    push_idle(3, 1'b0);
    for (int k = 0; sb.size() > 0; k++) begin
      exp_o = sb.pop_front(); got = sample(); n_chk++;
      if (got !== exp_o) begin n_fail++; $display("FAIL start_stop cyc %0d: got %b want %b", k, got, exp_o); end
      @(negedge clk);
    end
    pulse_start();
    push_pat(8, 1'b1); push_pat(8, 1'b0); push_idle(2, 1'b1);
    for (int k = 0; sb.size() > 0; k++) begin
      exp_o = sb.pop_front(); got = sample(); n_chk++;
      if (got !== exp_o) begin n_fail++; $display("FAIL start_busy cyc %0d: got %b want %b", k, got, exp_o); end
      bif.start = (k == 5 || k == 11);
      @(negedge clk);
    end
    bif.start = 1'b0;
  endtask

  initial begin
    test_reset();
    test_bounded();
    test_endless_solid();
    test_zero_on();
    test_handshake();
    test_simultaneous();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/blink_sequencer.md
Name: blink_sequencer

Overview:
- Controller that sequences the LED from a programmable on/off blink pattern driven by an internal clock-divider tick.
- Sits between the board clock/reset and the LED pin, replacing a fixed toggle divider.
- Configuration loads through a valid/ready handshake.
- start/stop control a bounded or endless repetition of the pattern, and completion is reported with a done pulse.

Parameters:
- TICK_DIV, 50000000, clk cycles per tick (0.5 s at 100 MHz); must be >= 2.
- CNT_W, 8, width of on/off tick counts.
- REP_W, 4, width of repetition count.
- TICK_W (localparam), $clog2(TICK_DIV), prescaler width.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- cfg_valid  in  1  config offered.
- cfg_ready  out  1  config can be accepted; high only in IDLE.
- cfg_on  in  CNT_W  ticks LED is on per cycle.
- cfg_off  in  CNT_W  ticks LED is off per cycle.
- cfg_reps  in  REP_W  on/off cycles to run; 0 = forever.
- start  in  1  level-sampled start request.
- stop  in  1  abort request.
- led  out  1  registered LED drive.
- busy  out  1  high while a sequence runs.
- done  out  1  one-cycle pulse on normal completion.
- tick  out  1  one-cycle prescaler pulse, for observation.

Behaviour:
- **Reset (rst=0, asynchronous):**
  - led=0, busy=0, done=0, tick=0, state=IDLE, prescaler=0.
  - Config regs reset to on=1, off=1, reps=0.
  - cfg_ready=1 during and after reset.
- **Handshake:**
  - cfg_valid && cfg_ready captures cfg_on/off/reps at that edge.
  - cfg_ready=0 in ON/OFF; cfg_valid is ignored there and must be held by the source.
- **FSM states:** IDLE, ON, OFF.
- **IDLE:**
  - start=1 && stop=0 with on_reg!=0: go to ON; led=1 and busy=1 from the next cycle; clear prescaler, phase counter=on_reg, rep counter=0.
  - start with on_reg==0: stay IDLE, done=1 for one cycle, busy stays 0.
  - start uses the config registered before this edge; config captured on the same edge takes effect at the next start.
- **Prescaler:**
  - Counts 0..TICK_DIV-1 only while busy; tick=1 in the cycle where count==TICK_DIV-1, then wraps to 0.
  - Restarts from 0 on every entry into ON from IDLE.
- **ON:**
  - Each tick decrements the phase counter.
  - Tick with phase==1 ends the ON phase: if off_reg!=0, go to OFF (led=0, phase=off_reg); else end-of-cycle.
- **OFF:**
  - Each tick decrements the phase counter.
  - Tick with phase==1 triggers end-of-cycle.
- **End-of-cycle:**
  - rep+1. If reps!=0 and rep+1==reps: go to IDLE, led=0, busy=0, done=1 for one cycle.
  - Otherwise go to ON, led=1, phase=on_reg.
  - With off_reg==0 and reps==0, led stays constantly 1.
- **Timing:** LED on exactly on_reg*TICK_DIV cycles and off exactly off_reg*TICK_DIV cycles; no extra cycles at phase boundaries.
- **stop:**
  - In any state, stop=1 forces IDLE at the next edge: led=0, busy=0, no done, prescaler cleared.
  - stop wins over start in the same cycle. stop in IDLE has no effect.
- **Other events:** start while busy is ignored. Counters never wrap because the phase is reloaded before reaching 0. rep counter saturates when reps==0.

Decomposition:
- Package blink_pkg holds:
  - state encoding constants (IDLE=2'd0, ON=2'd1, OFF=2'd2);
  - default TICK_DIV, CNT_W, REP_W;
  - config-register reset values.
- One sub-module, tick_prescaler, takes clk, rst, en, clr and produces tick; parameter TICK_DIV.

Test Plan (TICK_DIV=4):
- Reset: rst=0 mid-ON -> led, busy and tick go 0 immediately without a clock edge; cfg_ready=1; after release, start with defaults gives led high 4 cycles, low 4 cycles, repeating.
- Bounded run: cfg on=2, off=1, reps=2, then start -> led 1 for 8, 0 for 4, 1 for 8, 0 for 4 cycles; done pulses once on the following cycle; busy falls with it.
- Endless solid: on=3, off=0, reps=0 -> led stays 1 for 100+ cycles; stop -> led=0 and busy=0 next cycle, done never asserts.
- Zero-on: on=0, start -> done=1 for exactly one cycle, busy and led stay 0.
- Handshake: cfg_valid held during a run -> cfg_ready=0 and config unchanged; after done the config is captured in the first IDLE cycle, and the next start uses the new values.
- Simultaneous: start=stop=1 in IDLE -> no state change; start=1 while busy -> pattern timing unchanged.
